// File: rtl/pw_trigger_pkg.sv
// Shared definitions for the trigger pulse generator / monitor pair:
// FSM state encoding and the 24-bit result slot width used by both register banks.
package pw_trigger_pkg;

  localparam int pSLOT_WIDTH = 24;

  typedef enum logic [2:0] {
    pS_IDLE      = 3'd0,
    pS_ARMED     = 3'd1,
    pS_WAIT_RISE = 3'd2,
    pS_WAIT_FALL = 3'd3,
    pS_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/pw_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module pw_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pw_trigger_monitor.sv
// Times up to pNUM_TRIGGER_PULSES pulses on an asynchronous trigger line relative to a
// start event: low samples before each pulse and high samples of each pulse.
module pw_trigger_monitor
  import pw_trigger_pkg::*;
#(
  parameter int pTRIGGER_DELAY_WIDTH = 20,
  parameter int pTRIGGER_WIDTH_WIDTH = 17,
  parameter int pNUM_TRIGGER_PULSES  = 8,
  parameter int pNUM_TRIGGER_WIDTH   = 4,
  parameter int pTIMEOUT_WIDTH       = 24
) (
  input  logic                                       trigger_clk,
  input  logic                                       reset_n,
  input  logic                                       I_arm,
  input  logic                                       I_start,
  input  logic                                       I_trig_in,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]              I_num_pulses,
  input  logic [pTIMEOUT_WIDTH-1:0]                  I_timeout,
  output logic [pSLOT_WIDTH*pNUM_TRIGGER_PULSES-1:0] O_delay,
  output logic [pSLOT_WIDTH*pNUM_TRIGGER_PULSES-1:0] O_width,
  output logic [pNUM_TRIGGER_WIDTH-1:0]              O_count,
  output logic                                       O_busy,
  output logic                                       O_done,
  output logic                                       O_timeout,
  output logic                                       O_overflow,
  output state_t                                     O_state
);

  localparam int DW = pTRIGGER_DELAY_WIDTH;
  localparam int WW = pTRIGGER_WIDTH_WIDTH;
  localparam int NP = pNUM_TRIGGER_PULSES;
  localparam int NW = pNUM_TRIGGER_WIDTH;
  localparam int TW = pTIMEOUT_WIDTH;
  localparam int CW = (DW > WW) ? DW : WW;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [CW-1:0] DMAX  = CW'((64'd1 << DW) - 64'd1);
  localparam logic [CW-1:0] WMAX  = CW'((64'd1 << WW) - 64'd1);
  localparam logic [NW-1:0] NP_NW = NW'(NP);

  // Start goes through the same two flops as the trigger so both see equal latency.
  logic start_s;
  logic trig_s;

  pw_sync2 u_sync_start (
    .clk_i  (trigger_clk),
    .rst_ni (reset_n),
    .d_i    (I_start),
    .q_o    (start_s)
  );

  pw_sync2 u_sync_trig (
    .clk_i  (trigger_clk),
    .rst_ni (reset_n),
    .d_i    (I_trig_in),
    .q_o    (trig_s)
  );

  state_t        state_q;
  logic [DW-1:0] delay_q [NP];
  logic [WW-1:0] width_q [NP];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic [TW-1:0] timeout_q;
  logic [NW-1:0] k_q;
  logic [NW-1:0] k_d;
  logic [NW-1:0] count_q;
  logic [NW-1:0] target_q;
  logic [NW-1:0] target_d;
  logic          busy_q;
  logic          done_q;
  logic          timeout_flag_q;
  logic          overflow_q;
  logic          cnt_at_max;
  logic          tmo_hit;
  logic          last_pulse;
  logic [IW-1:0] idx;

  always_comb begin
    target_d = I_num_pulses;
    if (I_num_pulses == '0) begin
      target_d = NW'(1);
    end else if (I_num_pulses > NP_NW) begin
      target_d = NP_NW;
    end
    // Saturation limit follows the field being measured in the current phase.
    cnt_at_max = (state_q == pS_WAIT_FALL) ? (cnt_q == WMAX) : (cnt_q == DMAX);
    cnt_d      = cnt_at_max ? cnt_q : cnt_q + CW'(1);
    tcnt_d     = tcnt_q + TW'(1);
    tmo_hit    = (timeout_q != '0) && (tcnt_d == timeout_q);
    k_d        = k_q + NW'(1);
    last_pulse = (k_d == target_q);
    idx        = k_q[IW-1:0];
  end

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= pS_IDLE;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      timeout_q      <= '0;
      k_q            <= '0;
      count_q        <= '0;
      target_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      overflow_q     <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        delay_q[i] <= '0;
        width_q[i] <= '0;
      end
    end else if (I_arm) begin
      state_q        <= pS_ARMED;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      timeout_q      <= I_timeout;
      k_q            <= '0;
      count_q        <= '0;
      target_q       <= target_d;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      overflow_q     <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        delay_q[i] <= '0;
        width_q[i] <= '0;
      end
    end else begin
      case (state_q)
        pS_ARMED: begin
          if (start_s) begin
            state_q <= pS_WAIT_RISE;
            k_q     <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
          end
        end
        pS_WAIT_RISE: begin
          if (trig_s) begin
            delay_q[idx] <= cnt_q[DW-1:0];
            cnt_q        <= CW'(1);
            tcnt_q       <= '0;
            state_q      <= pS_WAIT_FALL;
          end else begin
            cnt_q  <= cnt_d;
            tcnt_q <= tcnt_d;
            if (cnt_at_max) overflow_q <= 1'b1;
            if (tmo_hit) begin
              state_q        <= pS_DONE;
              busy_q         <= 1'b0;
              done_q         <= 1'b1;
              timeout_flag_q <= 1'b1;
            end
          end
        end
        pS_WAIT_FALL: begin
          if (!trig_s) begin
            width_q[idx] <= cnt_q[WW-1:0];
            count_q      <= k_d;
            tcnt_q       <= '0;
            if (last_pulse) begin
              state_q <= pS_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              k_q     <= k_d;
              cnt_q   <= CW'(1);
              state_q <= pS_WAIT_RISE;
            end
          end else begin
            cnt_q  <= cnt_d;
            tcnt_q <= tcnt_d;
            if (cnt_at_max) overflow_q <= 1'b1;
            if (tmo_hit) begin
              state_q        <= pS_DONE;
              busy_q         <= 1'b0;
              done_q         <= 1'b1;
              timeout_flag_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_slot
    assign O_delay[g*pSLOT_WIDTH +: pSLOT_WIDTH] = pSLOT_WIDTH'(delay_q[g]);
    assign O_width[g*pSLOT_WIDTH +: pSLOT_WIDTH] = pSLOT_WIDTH'(width_q[g]);
  end

  assign O_count    = count_q;
  assign O_busy     = busy_q;
  assign O_done     = done_q;
  assign O_timeout  = timeout_flag_q;
  assign O_overflow = overflow_q;
  assign O_state    = state_q;

endmodule

// File: tb/tb_pw_trigger_monitor.sv
// Self-checking bench for pw_trigger_monitor: directed cases plus randomized pulse trains
// compared against a run-length reference model. Counter widths are reduced to keep saturation cheap.
module tb_pw_trigger_monitor;
  import pw_trigger_pkg::*;

  localparam int DW   = 12;
  localparam int WW   = 10;
  localparam int NP   = 8;
  localparam int NW   = 4;
  localparam int TW   = 24;
  localparam int DMAX = (1 << DW) - 1;
  localparam int WMAX = (1 << WW) - 1;

  logic                clk        = 1'b0;
  logic                rst_n      = 1'b0;
  logic                arm        = 1'b0;
  logic                start      = 1'b0;
  logic                trig       = 1'b0;
  logic [NW-1:0]       num_pulses = '0;
  logic [TW-1:0]       tmo        = '0;
  logic [24*NP-1:0]    o_delay;
  logic [24*NP-1:0]    o_width;
  logic [NW-1:0]       o_count;
  logic                o_busy;
  logic                o_done;
  logic                o_timeout;
  logic                o_overflow;
  state_t              o_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q[$];
  int          lo[0:9];
  int          hi[0:9];
  bit          samp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "watchdog expired");
  end

  pw_trigger_monitor #(
    .pTRIGGER_DELAY_WIDTH (DW),
    .pTRIGGER_WIDTH_WIDTH (WW),
    .pNUM_TRIGGER_PULSES  (NP),
    .pNUM_TRIGGER_WIDTH   (NW),
    .pTIMEOUT_WIDTH       (TW)
  ) dut (
    .trigger_clk  (clk),
    .reset_n      (rst_n),
    .I_arm        (arm),
    .I_start      (start),
    .I_trig_in    (trig),
    .I_num_pulses (num_pulses),
    .I_timeout    (tmo),
    .O_delay      (o_delay),
    .O_width      (o_width),
    .O_count      (o_count),
    .O_busy       (o_busy),
    .O_done       (o_done),
    .O_timeout    (o_timeout),
    .O_overflow   (o_overflow),
    .O_state      (o_state)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic arm_dut(input int num, input int t);
    @(negedge clk);
    arm        = 1'b1;
    num_pulses = NW'(num);
    tmo        = TW'(t);
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic build_samples(input int n);
    samp_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < lo[k]; i++) samp_q.push_back(1'b0);
      for (int i = 0; i < hi[k]; i++) samp_q.push_back(1'b1);
    end
    for (int i = 0; i < lo[n]; i++) samp_q.push_back(1'b0);
  endtask

  // Reference: the trigger is a sequence of runs lo0,hi0,lo1,...; sample i (1-based) is the
  // trigger value on the i-th cycle after the start cycle. Each run becomes a slot value,
  // saturated; a timeout fires once t samples in a row pass without a level change.
  task automatic model_push(input int num, input int t, input int n);
    int dly[NP];
    int wid[NP];
    int tgt, cnt, to, ov, idx, pos, len, nonedge, cons, mx, k;
    bit low;
    tgt = (num == 0) ? 1 : ((num > NP) ? NP : num);
    for (int i = 0; i < NP; i++) begin
      dly[i] = 0;
      wid[i] = 0;
    end
    cnt = 0; to = 0; ov = 0; idx = -1; pos = 0;
    for (int r = 0; r <= 2 * n; r++) begin
      low     = (r % 2 == 0);
      k       = r / 2;
      len     = low ? lo[k] : hi[k];
      mx      = low ? DMAX : WMAX;
      nonedge = (r == 0) ? len : len - 1;
      if (t != 0 && nonedge >= t) begin
        to   = 1;
        idx  = (r == 0) ? t : pos + 1 + t;
        cons = (r == 0) ? t : t + 1;
        if (cons > mx) ov = 1;
        break;
      end
      if (low && k == n) break;
      if (len > mx) ov = 1;
      if (low) begin
        dly[k] = (len > mx) ? mx : len;
      end else begin
        wid[k] = (len > mx) ? mx : len;
        cnt    = k + 1;
        if (cnt == tgt) begin
          idx = pos + len + 1;
          break;
        end
      end
      pos += len;
    end
    for (int i = 0; i < NP; i++) exp_q.push_back(24'(dly[i]));
    for (int i = 0; i < NP; i++) exp_q.push_back(24'(wid[i]));
    exp_q.push_back(24'(cnt));
    exp_q.push_back(24'(1));
    exp_q.push_back(24'(to));
    exp_q.push_back(24'(ov));
    exp_q.push_back(24'(idx + 2));
  endtask

  task automatic run_case(input string name, input int num, input int t, input int n);
    int seen;
    int budget;
    arm_dut(num, t);
    check({name, ".armed_state"}, 24'(o_state), 24'(pS_ARMED));
    check({name, ".armed_busy"}, 24'(o_busy), 24'(1));
    check({name, ".armed_done"}, 24'(o_done), 24'(0));
    model_push(num, t, n);
    build_samples(n);
    budget = samp_q.size() + t + 50;
    @(negedge clk);
    start = 1'b1;
    trig  = 1'b0;
    @(posedge clk);
    seen = -1;
    for (int j = 1; j <= budget && seen < 0; j++) begin
      @(negedge clk);
      start = 1'b0;
      trig  = (j <= samp_q.size()) ? samp_q[j-1] : 1'b0;
      @(posedge clk);
      #1;
      if (o_done) seen = j;
    end
    @(negedge clk);
    trig = 1'b0;
    // scoreboard
    for (int k = 0; k < NP; k++) check($sformatf("%s.delay%0d", name, k), o_delay[24*k +: 24], exp_q.pop_front());
    for (int k = 0; k < NP; k++) check($sformatf("%s.width%0d", name, k), o_width[24*k +: 24], exp_q.pop_front());
    check({name, ".count"}, 24'(o_count), exp_q.pop_front());
    check({name, ".done"}, 24'(o_done), exp_q.pop_front());
    check({name, ".timeout"}, 24'(o_timeout), exp_q.pop_front());
    check({name, ".overflow"}, 24'(o_overflow), exp_q.pop_front());
    check({name, ".done_cycle"}, 24'(seen), exp_q.pop_front());
    check({name, ".busy_end"}, 24'(o_busy), 24'(0));
    check({name, ".state_end"}, 24'(o_state), 24'(pS_DONE));
  endtask

  initial begin
    int tgt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.state", 24'(o_state), 24'(pS_IDLE));
    check("reset.count", 24'(o_count), 24'(0));
    check("reset.flags", 24'({o_busy, o_done, o_timeout, o_overflow}), 24'(0));
    check("reset.delay0", o_delay[23:0], 24'(0));
    check("reset.width7", o_width[24*7 +: 24], 24'(0));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_start.state", 24'(o_state), 24'(pS_IDLE));
    check("idle_start.busy", 24'(o_busy), 24'(0));

    lo[0] = 10; hi[0] = 5; lo[1] = 3;
    run_case("single", 1, 0, 1);

    lo[0] = 4; hi[0] = 2; lo[1] = 7; hi[1] = 3; lo[2] = 1; hi[2] = 1; lo[3] = 2;
    run_case("three", 3, 0, 3);

    lo[0] = 110;
    run_case("timeout", 2, 100, 0);

    lo[0] = 3; hi[0] = 1030; lo[1] = 2;
    run_case("width_sat", 1, 0, 1);

    lo[0] = 4100; hi[0] = 2; lo[1] = 1;
    run_case("delay_sat", 1, 0, 1);

    lo[0] = 0; hi[0] = 4; lo[1] = 2;
    run_case("high_at_start", 0, 0, 1);

    for (int k = 0; k < NP; k++) begin
      lo[k] = k + 1;
      hi[k] = 9 - k;
    end
    lo[NP] = 2;
    run_case("clamp8", 15, 0, NP);

    lo[0] = 1; hi[0] = 4; lo[1] = 3; hi[1] = 6; lo[2] = 5;
    run_case("timeout_in_high", 3, 5, 2);

    // Abort by re-arm while a pulse is being timed.
    arm_dut(2, 0);
    lo[0] = 2; hi[0] = 3; lo[1] = 2; hi[1] = 20; lo[2] = 1;
    build_samples(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      start = 1'b0;
      trig  = samp_q[j-1];
      @(posedge clk);
    end
    #1;
    check("abort.pre_state", 24'(o_state), 24'(pS_WAIT_FALL));
    check("abort.pre_count", 24'(o_count), 24'(1));
    check("abort.pre_width0", o_width[23:0], 24'(3));
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm  = 1'b0;
    trig = 1'b0;
    check("abort.state", 24'(o_state), 24'(pS_ARMED));
    check("abort.count", 24'(o_count), 24'(0));
    check("abort.done", 24'(o_done), 24'(0));
    check("abort.busy", 24'(o_busy), 24'(1));
    check("abort.delay0", o_delay[23:0], 24'(0));
    check("abort.width0", o_width[23:0], 24'(0));

    for (int it = 0; it < 20; it++) begin
      int num;
      int t;
      num = $urandom_range(0, 15);
      tgt = (num == 0) ? 1 : ((num > NP) ? NP : num);
      lo[0] = $urandom_range(0, 15);
      for (int k = 0; k < tgt; k++) begin
        if (k > 0) lo[k] = $urandom_range(1, 15);
        hi[k] = $urandom_range(1, 15);
      end
      lo[tgt] = 3;
      t = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 12) : 0;
      run_case($sformatf("rand%0d", it), num, t, tgt);
    end

    // Asynchronous reset in the middle of a run.
    arm_dut(2, 0);
    lo[0] = 1; hi[0] = 2; lo[1] = 1; hi[1] = 30; lo[2] = 1;
    build_samples(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      start = 1'b0;
      trig  = samp_q[j-1];
      @(posedge clk);
    end
    #1;
    check("areset.pre_count", 24'(o_count), 24'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.state", 24'(o_state), 24'(pS_IDLE));
    check("areset.count", 24'(o_count), 24'(0));
    check("areset.width0", o_width[23:0], 24'(0));
    check("areset.flags", 24'({o_busy, o_done, o_timeout, o_overflow}), 24'(0));
    trig = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
